// File: rtl/sd_spi_target_pkg.sv
// Constants and command-framer state encoding shared by the SPI-mode SD target.
package sd_spi_target_pkg;

  localparam logic [1:0] SD_START_BITS = 2'b01;
  localparam logic [7:0] SD_FILL       = 8'hFF;
  localparam int         SD_CMD_BYTES  = 6;
  localparam int         SD_ARG_BYTES  = SD_CMD_BYTES - 2;

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_ARG0,
    CMD_ARG1,
    CMD_ARG2,
    CMD_ARG3,
    CMD_CRC
  } cmd_state_e;

endpackage

// File: rtl/sd_spi_target_resp_fifo.sv
// Response byte FIFO; head is visible combinationally, push/pop land on the next clk.
// Push while full is dropped unless a same-clk pop frees a slot; flush beats push.
module resp_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop) & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sd_spi_target.sv
// SPI-mode SD target: oversampled mode-0 slave framing 6-byte commands; rx_strobe lands 3 clk
// after the raw 8th SCLK rise. No backpressure toward the master: queued responses, else 0xFF.
module sd_spi_target
  import sd_spi_target_pkg::*;
#(
  parameter int RESP_DEPTH_LOG2 = 2,
  parameter int NCR_BYTES       = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        sdCS,
  input  logic        sdSCLK,
  input  logic        sdMOSI,
  output logic        sdMISO,
  output logic        sdMISO_oe,
  output logic [7:0]  rx_data,
  output logic        rx_strobe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  output logic        cmd_error,
  input  logic [7:0]  resp_data,
  input  logic        resp_wr,
  output logic        resp_full,
  output logic        resp_empty
);

  localparam logic [3:0] NCR_MAX = 4'(NCR_BYTES);

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic sel_q, sel_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_q, tx_d;
  logic [3:0] ncr_q, ncr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic rx_strobe_q, rx_strobe_d;
  logic cmd_valid_q, cmd_valid_d;
  logic cmd_error_q, cmd_error_d;
  logic [5:0] idx_q, idx_d, cmd_index_q, cmd_index_d;
  logic [8*SD_ARG_BYTES-1:0] arg_sh_q, arg_sh_d, cmd_arg_q, cmd_arg_d;
  logic [6:0] cmd_crc_q, cmd_crc_d;
  cmd_state_e state_q, state_d;

  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [7:0] rx_byte;
  logic       fifo_pop, fifo_flush;
  logic [7:0] fifo_head;

  resp_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (RESP_DEPTH_LOG2)
  ) u_resp_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (resp_wr),
    .push_data (resp_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .full      (resp_full),
    .empty     (resp_empty)
  );

  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q & cs_sync_q;
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign rx_byte   = {rx_sh_q, mosi_sync_q};

  always_comb begin
    sel_d       = sel_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_d        = tx_q;
    ncr_d       = ncr_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_error_d = 1'b0;
    idx_d       = idx_q;
    arg_sh_d    = arg_sh_q;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_crc_d   = cmd_crc_q;
    state_d     = state_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    if (cs_rise) begin
      sel_d      = 1'b0;
      tx_d       = SD_FILL;
      bit_cnt_d  = '0;
      ncr_d      = '0;
      state_d    = CMD_IDLE;
      fifo_flush = 1'b1;
    end else if (cs_fall) begin
      sel_d     = 1'b1;
      bit_cnt_d = '0;
      tx_d      = SD_FILL;
    end else if (sel_q && sclk_rise) begin
      rx_sh_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d   = rx_byte;
        rx_strobe_d = 1'b1;
        case (state_q)
          CMD_IDLE: begin
            if (rx_byte[7:6] == SD_START_BITS) begin
              idx_d   = rx_byte[5:0];
              ncr_d   = '0;
              state_d = CMD_ARG0;
            end
          end
          CMD_ARG0: begin arg_sh_d = {arg_sh_q[23:0], rx_byte}; state_d = CMD_ARG1; end
          CMD_ARG1: begin arg_sh_d = {arg_sh_q[23:0], rx_byte}; state_d = CMD_ARG2; end
          CMD_ARG2: begin arg_sh_d = {arg_sh_q[23:0], rx_byte}; state_d = CMD_ARG3; end
          CMD_ARG3: begin arg_sh_d = {arg_sh_q[23:0], rx_byte}; state_d = CMD_CRC;  end
          CMD_CRC: begin
            if (rx_byte[0]) begin
              cmd_index_d = idx_q;
              cmd_arg_d   = arg_sh_q;
              cmd_crc_d   = rx_byte[7:1];
              cmd_valid_d = 1'b1;
            end else begin
              cmd_error_d = 1'b1;
            end
            state_d = CMD_IDLE;
          end
          default: state_d = CMD_IDLE;
        endcase
      end
    end else if (sel_q && sclk_fall) begin
      // Responses are held back while a frame is in flight, then NCR filler counts from its end.
      if (bit_cnt_q != 3'd0) begin
        tx_d = {tx_q[6:0], 1'b1};
      end else if (state_q != CMD_IDLE) begin
        tx_d = SD_FILL;
      end else if (ncr_q < NCR_MAX) begin
        tx_d  = SD_FILL;
        ncr_d = ncr_q + 4'd1;
      end else if (!resp_empty) begin
        tx_d     = fifo_head;
        fifo_pop = 1'b1;
      end else begin
        tx_d = SD_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b1;
      mosi_sync_q <= 1'b1;
      sel_q       <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_q        <= SD_FILL;
      ncr_q       <= '0;
      rx_data_q   <= '0;
      rx_strobe_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
      idx_q       <= '0;
      arg_sh_q    <= '0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      cmd_crc_q   <= '0;
      state_q     <= CMD_IDLE;
    end else begin
      cs_meta_q   <= sdCS;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= sdSCLK;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= sdMOSI;
      mosi_sync_q <= mosi_meta_q;
      sel_q       <= sel_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_q        <= tx_d;
      ncr_q       <= ncr_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_error_q <= cmd_error_d;
      idx_q       <= idx_d;
      arg_sh_q    <= arg_sh_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      cmd_crc_q   <= cmd_crc_d;
      state_q     <= state_d;
    end
  end

  assign sdMISO    = tx_q[7];
  assign sdMISO_oe = sel_q;
  assign rx_data   = rx_data_q;
  assign rx_strobe = rx_strobe_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_error = cmd_error_q;
  assign cmd_index = cmd_index_q;
  assign cmd_arg   = cmd_arg_q;
  assign cmd_crc   = cmd_crc_q;

endmodule
